prime_fetch: RTL and testbench
==============================

Name: prime_fetch

Overview:
- Downstream consumer and controller of the prime generator.
- Issues single-cycle `go` requests to the generator and waits for each result. Captures each new prime into a small FIFO.
- Presents the FIFO contents on a valid/ready stream to later stages (display, UART, checker).
- Provides flow control: a new prime is never requested unless FIFO space for it is already reserved.

Parameters:
- WIDTH_LOG, 4, log2 of prime width; WIDTH = 1 << WIDTH_LOG (must match the generator).
- DEPTH_LOG, 2, log2 of FIFO depth; DEPTH = 1 << DEPTH_LOG entries.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- en  in  1  enables requesting new primes
- gen_ready  in  1  generator ready flag
- gen_error  in  1  generator error flag (overflow)
- gen_res  in  WIDTH  generator result
- gen_go  out  1  single-cycle request pulse to the generator
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head
- out_data  out  WIDTH  FIFO head prime
- out_error  out  1  sticky: generator reported error; no further requests
- level  out  DEPTH_LOG+1  FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (async, immediate):
  - state = IDLE; gen_go = 0, out_valid = 0, out_data = 0, out_error = 0, level = 0.
  - FIFO pointers cleared; entries are not preserved.
  - The generator must be reset in the same cycle. The initial generator value 1 is never captured.
- State machine (registered, one state per cycle minimum):
  - IDLE: if en && !out_error && gen_ready && (level + pop_this_cycle_excluded) < DEPTH, i.e. level < DEPTH → ISSUE.
  - ISSUE: gen_go = 1 for exactly this cycle → SETTLE.
  - SETTLE: one dead cycle; gen_ready is ignored, because the generator drops ready on the edge after sampling go → WAIT.
  - WAIT: stays until gen_ready = 1. Then:
    - if gen_error: out_error <= 1 → HALT, nothing pushed;
    - else push gen_res into the FIFO → IDLE.
  - HALT: terminal until reset. The FIFO still drains normally.
- Slot reservation:
  - The IDLE→ISSUE decision uses the level of the current cycle.
  - At most one request is in flight. A push therefore can never hit a full FIFO.
  - Push-when-full is an assertion failure.
- FIFO:
  - First-word-fall-through; out_data is valid whenever out_valid = 1. out_valid = (level != 0).
  - Pop happens when out_valid && out_ready.
  - Simultaneous push and pop: level unchanged, both pointers advance.
  - Pop with level = 0 is ignored.
  - Pointers wrap modulo DEPTH. level is a separate counter and is the sole source of full/empty.
- Latency:
  - Minimum from IDLE with space to gen_go is 1 cycle.
  - gen_res to out_valid is 1 cycle after the push edge.
- Throughput: back-to-back primes need at least 4 cycles plus generator time.
- Deasserting en: only stops future requests. A request already in flight completes and is pushed.
- out_data holds its last value when empty; it is not X.

Optional Feature:
- Macro PRIME_FETCH_TIMEOUT_EN.
- When defined:
  - a 16-bit watchdog counts cycles spent in WAIT;
  - reaching 16'hFFFF sets out_error and enters HALT;
  - the counter clears on entering WAIT.
- When undefined: no counter; WAIT may last indefinitely.

Decomposition:
- Shared header/package prime_pkg:
  - state encodings (IDLE, ISSUE, SETTLE, WAIT, HALT as 3-bit constants);
  - WIDTH derivation from WIDTH_LOG;
  - watchdog limit constant.
- Sub-module sync_fifo (params WIDTH, DEPTH_LOG): holds storage, pointers and level, with push/pop/full/empty.
- prime_fetch keeps only the FSM, the reservation logic and the error latch.

Test Plan:
- Reset, en = 1, behavioural generator model, out_ready = 1 → out_data stream 2, 3, 5, 7, 11, 13; exactly one gen_go per value; 1 never output.
- out_ready = 0, DEPTH = 4 → level reaches 4 holding 2, 3, 5, 7; no gen_go while level = 4. Pop once → exactly one new gen_go; 11 appended.
- Pop and push in the same cycle at level = 2 → level stays 2; order preserved across pointer wrap (8 or more values).
- Model asserts gen_error with gen_ready after the 3rd request → out_error = 1; no further gen_go; the 2 prior primes still drain.
- Assert rst mid-WAIT with level = 3 → outputs clear asynchronously, before the next clk edge. After release, the first output is 2 again.
- With PRIME_FETCH_TIMEOUT_EN, model never raises gen_ready → out_error rises 65535 cycles after entering WAIT. Without the macro, out_error stays 0.

Source files
------------

// File: rtl/prime_fetch_pkg.sv
// prime_fetch_pkg: shared definitions for the prime fetch slice.
// FSM state encodings, prime width derivation and the WAIT watchdog limit.
// The watchdog only exists when PRIME_FETCH_TIMEOUT_EN is defined.
package prime_fetch_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_SETTLE = 3'd2,
      S_WAIT   = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   // Cycles tolerated in WAIT before the generator is declared dead.
   localparam logic [15:0] WDOG_LIMIT = 16'hFFFF;

   // Prime width in bits from its log2; must agree with the generator.
   function automatic int prime_width(input int width_log);
      return 1 << width_log;
   endfunction

endpackage

// File: rtl/prime_fetch_if.sv
// prime_fetch_if: generator handshake plus output stream of prime_fetch.
// master = prime_fetch side, slave = generator/consumer side.
interface prime_fetch_if
   import prime_fetch_pkg::*;
#(
   parameter int WIDTH_LOG = 4,
   parameter int DEPTH_LOG = 2
) ();

   localparam int WIDTH = prime_width(WIDTH_LOG);

   logic             en;
   logic             gen_ready;
   logic             gen_error;
   logic [WIDTH-1:0] gen_res;
   logic             gen_go;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_error;
   logic [DEPTH_LOG:0] level;

   modport master (
      input  en, gen_ready, gen_error, gen_res, out_ready,
      output gen_go, out_valid, out_data, out_error, level
   );

   modport slave (
      output en, gen_ready, gen_error, gen_res, out_ready,
      input  gen_go, out_valid, out_data, out_error, level
   );

endinterface

// File: rtl/prime_fetch_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with a registered head word.
// level is the only source of full/empty; pointers just wrap.
// The head register keeps its last value when the FIFO drains.
module sync_fifo #(
   parameter int WIDTH     = 16,
   parameter int DEPTH_LOG = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [WIDTH-1:0]     push_data,
   input  logic                 pop,
   output logic [WIDTH-1:0]     head,
   output logic                 full,
   output logic                 empty,
   output logic [DEPTH_LOG:0]   level
);

   localparam int DEPTH = 1 << DEPTH_LOG;

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [DEPTH_LOG-1:0] wr_ptr, rd_ptr, rd_nxt;
   logic [DEPTH_LOG:0]   lvl_q, lvl_nxt;
   logic [WIDTH-1:0]     head_q;
   logic                 do_pop;

   assign do_pop = pop && (lvl_q != '0);
   assign full   = (lvl_q == (DEPTH_LOG+1)'(DEPTH));
   assign empty  = (lvl_q == '0);
   assign level  = lvl_q;
   assign head   = head_q;

   // Next read pointer and occupancy for this cycle's push/pop mix.
   always_comb begin
      rd_nxt  = do_pop ? rd_ptr + 1'b1 : rd_ptr;
      lvl_nxt = lvl_q;
      if (push && !do_pop) lvl_nxt = lvl_q + 1'b1;
      if (!push && do_pop) lvl_nxt = lvl_q - 1'b1;
   end

   // Storage write; contents are not reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // Pointers, level and head word; the new head bypasses storage when it is being written now.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         lvl_q  <= '0;
         head_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr <= rd_nxt;
         lvl_q  <= lvl_nxt;
         if (lvl_nxt != '0)
            head_q <= (push && (wr_ptr == rd_nxt)) ? push_data : mem[rd_nxt];
      end
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push && full && !do_pop));

endmodule

// File: rtl/prime_fetch.sv
// prime_fetch: requests primes from the generator one at a time and queues them.
// A request is issued only when the FIFO has a free slot, so a push never overflows.
// Optional watchdog on WAIT: define PRIME_FETCH_TIMEOUT_EN.
module prime_fetch
   import prime_fetch_pkg::*;
#(
   parameter int WIDTH_LOG = 4,
   parameter int DEPTH_LOG = 2
) (
   input  logic         clk,
   input  logic         rst,
   prime_fetch_if.master bus
);

   localparam int WIDTH = prime_width(WIDTH_LOG);

   state_t             state;
   logic               gen_go_q;
   logic               out_error_q;
   logic               push;
   logic               full;
   logic               empty;
   logic [WIDTH-1:0]   head;
   logic [DEPTH_LOG:0] level;
   logic               wdog_expired;

   assign push = (state == S_WAIT) && bus.gen_ready && !bus.gen_error;

   sync_fifo #(
      .WIDTH     (WIDTH),
      .DEPTH_LOG (DEPTH_LOG)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (bus.gen_res),
      .pop       (bus.out_ready),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .level     (level)
   );

   assign bus.gen_go    = gen_go_q;
   assign bus.out_error = out_error_q;
   assign bus.out_valid = !empty;
   assign bus.out_data  = head;
   assign bus.level     = level;

`ifdef PRIME_FETCH_TIMEOUT_EN
   logic [15:0] wdog;

   // Count cycles spent in WAIT, restarting every time WAIT is entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wdog <= '0;
      else if (state == S_SETTLE)
         wdog <= '0;
      else if (state == S_WAIT && wdog != WDOG_LIMIT)
         wdog <= wdog + 16'd1;
   end

   assign wdog_expired = (state == S_WAIT) && (wdog == WDOG_LIMIT - 16'd1);
`else
   assign wdog_expired = 1'b0;
`endif

   // Request sequencer: IDLE -> ISSUE (go pulse) -> SETTLE -> WAIT -> IDLE, or HALT on error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         gen_go_q    <= 1'b0;
         out_error_q <= 1'b0;
      end else begin
         gen_go_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.en && !out_error_q && bus.gen_ready && !full) begin
                  state    <= S_ISSUE;
                  gen_go_q <= 1'b1;
               end
            end
            S_ISSUE:  state <= S_SETTLE;
            // Generator drops ready on the edge after it samples go; skip that stale cycle.
            S_SETTLE: state <= S_WAIT;
            S_WAIT: begin
               if (bus.gen_ready) begin
                  if (bus.gen_error) begin
                     out_error_q <= 1'b1;
                     state       <= S_HALT;
                  end else begin
                     state <= S_IDLE;
                  end
               end else if (wdog_expired) begin
                  out_error_q <= 1'b1;
                  state       <= S_HALT;
               end
            end
            S_HALT:   state <= S_HALT;
            default:  state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prime_fetch.sv
// tb_prime_fetch: directed bench for prime_fetch with a behavioural prime generator.
module tb_prime_fetch;

   logic clk = 1'b0;
   logic rst = 1'b1;

   prime_fetch_if #(.WIDTH_LOG(4), .DEPTH_LOG(2)) bus ();

   prime_fetch #(.WIDTH_LOG(4), .DEPTH_LOG(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Generator model controls
   int unsigned err_at = 0;
   bit          hang   = 1'b0;
   logic        busy;
   int unsigned cnt;
   int unsigned req_cnt;

   // Observation
   logic [15:0] got [$];
   int unsigned go_cnt = 0;
   int unsigned go_base = 0;
   int unsigned got_base = 0;

   int checks = 0;
   int errors = 0;

   int unsigned primes [14] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43};

   function automatic logic [15:0] next_prime(input logic [15:0] n);
      bit p;
      for (int c = int'(n) + 1; c < 70000; c++) begin
         p = 1'b1;
         for (int d = 2; d * d <= c; d++)
            if (c % d == 0) p = 1'b0;
         if (p) return 16'(c);
      end
      return 16'd0;
   endfunction

   // Behavioural generator: starts at 1 with ready; go drops ready, result appears a few cycles later.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.gen_res   <= 16'd1;
         bus.gen_ready <= 1'b1;
         bus.gen_error <= 1'b0;
         busy          <= 1'b0;
         cnt           <= 0;
         req_cnt       <= 0;
      end else begin
         if (bus.gen_go && bus.gen_ready) begin
            bus.gen_ready <= 1'b0;
            busy          <= 1'b1;
            cnt           <= 2 + (req_cnt % 3);
            req_cnt       <= req_cnt + 1;
         end else if (busy && !hang) begin
            if (cnt == 0) begin
               busy          <= 1'b0;
               bus.gen_ready <= 1'b1;
               bus.gen_res   <= next_prime(bus.gen_res);
               if (err_at != 0 && req_cnt == err_at) bus.gen_error <= 1'b1;
            end else begin
               cnt <= cnt - 1;
            end
         end
      end
   end

   // Record every popped word and every go pulse
   always @(posedge clk) begin
      if (!rst) begin
         if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
         if (bus.gen_go) go_cnt <= go_cnt + 1;
      end
   end

   task automatic apply_reset();
      bus.en        = 1'b0;
      bus.out_ready = 1'b0;
      err_at        = 0;
      hang          = 1'b0;
      rst           = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      got_base = got.size();
      go_base  = go_cnt;
   endtask

   task automatic wait_level(input logic [2:0] target, input string name);
      int n;
      n = 0;
      while (bus.level !== target && n < 600) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.level !== target) begin
         errors++;
         $display("FAIL %s level timeout: got %0d want %0d", name, bus.level, target);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.en = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.gen_go !== 1'b0)    begin errors++; $display("FAIL reset_gen_go got %b want 0", bus.gen_go); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
      checks++; if (bus.out_data !== 16'd0) begin errors++; $display("FAIL reset_out_data got %0d want 0", bus.out_data); end
      checks++; if (bus.out_error !== 1'b0) begin errors++; $display("FAIL reset_out_error got %b want 0", bus.out_error); end
      checks++; if (bus.level !== 3'd0)     begin errors++; $display("FAIL reset_level got %0d want 0", bus.level); end
   endtask

   task automatic test_stream();
      int n;
      apply_reset();
      bus.en = 1'b1;
      bus.out_ready = 1'b1;
      n = 0;
      while (got.size() - got_base < 6 && n < 600) begin
         @(negedge clk);
         n++;
      end
      bus.en = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (got.size() - got_base < 6) begin
         errors++; $display("FAIL stream_count got %0d want >=6", got.size() - got_base);
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[got_base + i] !== 16'(primes[i])) begin
               errors++; $display("FAIL stream_val[%0d] got %0d want %0d", i, got[got_base + i], primes[i]);
            end
         end
      end
      checks++;
      if (go_cnt - go_base !== got.size() - got_base) begin
         errors++; $display("FAIL stream_go_per_value got %0d go pulses want %0d", go_cnt - go_base, got.size() - got_base);
      end
   endtask

   task automatic test_full();
      apply_reset();
      bus.en = 1'b1;
      wait_level(3'd4, "full_fill");
      repeat (30) @(negedge clk);
      checks++; if (bus.level !== 3'd4)     begin errors++; $display("FAIL full_level got %0d want 4", bus.level); end
      checks++; if (bus.out_data !== 16'd2) begin errors++; $display("FAIL full_head got %0d want 2", bus.out_data); end
      checks++; if (go_cnt - go_base !== 4) begin errors++; $display("FAIL full_no_go got %0d go pulses want 4", go_cnt - go_base); end
      @(posedge clk); #1 bus.out_ready = 1'b1;
      @(posedge clk); #1 bus.out_ready = 1'b0;
      repeat (40) @(negedge clk);
      checks++; if (go_cnt - go_base !== 5) begin errors++; $display("FAIL full_one_go got %0d go pulses want 5", go_cnt - go_base); end
      checks++; if (bus.level !== 3'd4)     begin errors++; $display("FAIL full_refill got %0d want 4", bus.level); end
      checks++; if (bus.out_data !== 16'd3) begin errors++; $display("FAIL full_head2 got %0d want 3", bus.out_data); end
      bus.en = 1'b0;
      bus.out_ready = 1'b1;
      wait_level(3'd0, "full_drain");
      repeat (3) @(negedge clk);
      checks++;
      if (got.size() - got_base !== 5) begin
         errors++; $display("FAIL full_drain_count got %0d want 5", got.size() - got_base);
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[got_base + i] !== 16'(primes[i])) begin
               errors++; $display("FAIL full_val[%0d] got %0d want %0d", i, got[got_base + i], primes[i]);
            end
         end
      end
      checks++;
      if (bus.out_data !== 16'd11) begin errors++; $display("FAIL empty_hold got %0d want 11", bus.out_data); end
   endtask

   task automatic test_back_to_back();
      int n;
      apply_reset();
      bus.en = 1'b1;
      wait_level(3'd2, "b2b_fill");
      for (int k = 0; k < 8; k++) begin
         n = 0;
         // Push cycle: DUT sits in WAIT while the model shows a fresh ready result
         while (!(bus.gen_ready && dut.state == prime_fetch_pkg::S_WAIT) && n < 100) begin
            @(negedge clk);
            n++;
         end
         bus.out_ready = 1'b1;
         @(posedge clk); #1 bus.out_ready = 1'b0;
         checks++;
         if (bus.level !== 3'd2) begin errors++; $display("FAIL b2b_level[%0d] got %0d want 2", k, bus.level); end
      end
      bus.en = 1'b0;
      repeat (20) @(negedge clk);
      bus.out_ready = 1'b1;
      wait_level(3'd0, "b2b_drain");
      repeat (3) @(negedge clk);
      checks++;
      if (got.size() - got_base !== 10) begin
         errors++; $display("FAIL b2b_count got %0d want 10", got.size() - got_base);
      end else begin
         for (int i = 0; i < 10; i++) begin
            checks++;
            if (got[got_base + i] !== 16'(primes[i])) begin
               errors++; $display("FAIL b2b_val[%0d] got %0d want %0d", i, got[got_base + i], primes[i]);
            end
         end
      end
   endtask

   task automatic test_error();
      int n;
      apply_reset();
      err_at = 3;
      bus.en = 1'b1;
      n = 0;
      while (bus.out_error !== 1'b1 && n < 600) begin
         @(negedge clk);
         n++;
      end
      checks++; if (bus.out_error !== 1'b1) begin errors++; $display("FAIL err_flag got %b want 1", bus.out_error); end
      checks++; if (bus.level !== 3'd2)     begin errors++; $display("FAIL err_level got %0d want 2", bus.level); end
      repeat (30) @(negedge clk);
      checks++; if (go_cnt - go_base !== 3) begin errors++; $display("FAIL err_no_go got %0d go pulses want 3", go_cnt - go_base); end
      checks++; if (bus.out_error !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", bus.out_error); end
      bus.out_ready = 1'b1;
      wait_level(3'd0, "err_drain");
      repeat (3) @(negedge clk);
      checks++;
      if (got.size() - got_base !== 2) begin
         errors++; $display("FAIL err_drain_count got %0d want 2", got.size() - got_base);
      end else begin
         checks++; if (got[got_base] !== 16'd2)     begin errors++; $display("FAIL err_val0 got %0d want 2", got[got_base]); end
         checks++; if (got[got_base + 1] !== 16'd3) begin errors++; $display("FAIL err_val1 got %0d want 3", got[got_base + 1]); end
      end
   endtask

   task automatic test_async_reset();
      int n;
      apply_reset();
      bus.en = 1'b1;
      wait_level(3'd3, "ar_fill");
      n = 0;
      while (bus.gen_ready !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checks++;
      if (dut.state !== prime_fetch_pkg::S_WAIT) begin errors++; $display("FAIL ar_in_wait got %0d want %0d", dut.state, prime_fetch_pkg::S_WAIT); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.level !== 3'd0)     begin errors++; $display("FAIL ar_level got %0d want 0", bus.level); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b want 0", bus.out_valid); end
      checks++; if (bus.out_data !== 16'd0) begin errors++; $display("FAIL ar_data got %0d want 0", bus.out_data); end
      checks++; if (bus.gen_go !== 1'b0)    begin errors++; $display("FAIL ar_go got %b want 0", bus.gen_go); end
      @(posedge clk); #1 rst = 1'b0;
      got_base = got.size();
      go_base  = go_cnt;
      bus.out_ready = 1'b1;
      n = 0;
      while (got.size() == got_base && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (got.size() == got_base) begin
         errors++; $display("FAIL ar_restart no output after reset");
      end else if (got[got_base] !== 16'd2) begin
         errors++; $display("FAIL ar_first got %0d want 2", got[got_base]);
      end
      bus.en = 1'b0;
   endtask

   task automatic test_timeout();
      int n;
      apply_reset();
      hang = 1'b1;
      bus.en = 1'b1;
      bus.out_ready = 1'b1;
`ifdef PRIME_FETCH_TIMEOUT_EN
      n = 0;
      while (bus.out_error !== 1'b1 && n < 70000) begin
         @(negedge clk);
         n++;
      end
      checks++; if (bus.out_error !== 1'b1) begin errors++; $display("FAIL to_flag got %b want 1", bus.out_error); end
      checks++; if (n < 65500) begin errors++; $display("FAIL to_early after %0d cycles want about 65535", n); end
`else
      n = 0;
      repeat (300) @(negedge clk);
      checks++; if (bus.out_error !== 1'b0) begin errors++; $display("FAIL to_flag got %b want 0", bus.out_error); end
`endif
      checks++; if (go_cnt - go_base !== 1) begin errors++; $display("FAIL to_go got %0d go pulses want 1", go_cnt - go_base); end
   endtask

   initial begin
      bus.en        = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_stream();
      test_full();
      test_back_to_back();
      test_error();
      test_async_reset();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
